// File: rtl/loawa_pkg.sv
// rtl/loawa_pkg.sv - shared states, default parameters and helpers for the loawa accumulator
package loawa_pkg;

  localparam int DEF_ADDER_LENGTH   = 32;
  localparam int DEF_IMPRECISE_PART = 16;
  localparam int DEF_ACC_LEN        = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Width needed to hold a beat count from 0 up to and including acc_len.
  function automatic int cnt_width(input int acc_len);
    return $clog2(acc_len + 1);
  endfunction

endpackage

// File: rtl/loawa_addsub_core.sv
// rtl/loawa_addsub_core.sv - combinational lower-part-OR approximate add/subtract with saturation
module loawa_addsub_core #(
  parameter int ADDER_LENGTH   = 32,
  parameter int IMPRECISE_PART = 16
) (
  input  logic [ADDER_LENGTH-1:0] a,
  input  logic [ADDER_LENGTH-1:0] b,
  input  logic                    sub,
  output logic [ADDER_LENGTH-1:0] r,
  output logic                    ovf
);

  localparam int N = ADDER_LENGTH;
  localparam int L = IMPRECISE_PART;
  localparam int H = N - L;

  logic [H:0] hi_ext;

  // Exact upper part with one guard bit for carry/borrow; approximate low bits
  // need no carry chain, and an overflow clamps the whole word.
  always_comb begin
    if (sub) begin
      hi_ext = {1'b0, a[N-1:L]} - {1'b0, b[N-1:L]};
    end else begin
      hi_ext = {1'b0, a[N-1:L]} + {1'b0, b[N-1:L]};
    end
    ovf = hi_ext[H];
    if (ovf) begin
      r = sub ? '0 : '1;
    end else if (sub) begin
      r = {hi_ext[H-1:0], a[L-1:0] & ~b[L-1:0]};
    end else begin
      r = {hi_ext[H-1:0], a[L-1:0] | b[L-1:0]};
    end
  end

endmodule

// File: rtl/loawa_accum.sv
// rtl/loawa_accum.sv - streaming approximate accumulator with group close and held result
module loawa_accum
  import loawa_pkg::*;
#(
  parameter int ADDER_LENGTH   = DEF_ADDER_LENGTH,
  parameter int IMPRECISE_PART = DEF_IMPRECISE_PART,
  parameter int ACC_LEN        = DEF_ACC_LEN
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ADDER_LENGTH-1:0]           in_data,
  input  logic                              in_sub,
  input  logic                              in_last,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ADDER_LENGTH-1:0]           out_data,
  output logic                              out_sat,
  output logic [cnt_width(ACC_LEN)-1:0]     out_count
);

  localparam int CW = cnt_width(ACC_LEN);
  localparam logic [CW-1:0] ACC_LEN_C = CW'(ACC_LEN);

  state_t state, state_nxt;

  logic [ADDER_LENGTH-1:0] acc;
  logic [CW-1:0]           cnt;
  logic                    sat;

  logic [ADDER_LENGTH-1:0] sum;
  logic                    ovf;
  logic [CW-1:0]           cnt_inc;
  logic                    accept;
  logic                    closing;
  logic                    release_out;

  // The accumulator is already zero in IDLE, so the first beat folds into 0.
  loawa_addsub_core #(
    .ADDER_LENGTH  (ADDER_LENGTH),
    .IMPRECISE_PART(IMPRECISE_PART)
  ) u_core (
    .a  (acc),
    .b  (in_data),
    .sub(in_sub),
    .r  (sum),
    .ovf(ovf)
  );

  assign in_ready    = (state != HOLD);
  assign out_valid   = (state == HOLD);
  assign out_data    = acc;
  assign out_sat     = sat;
  assign out_count   = cnt;
  assign accept      = in_valid && in_ready;
  assign cnt_inc     = cnt + 1'b1;
  assign closing     = in_last || (cnt_inc == ACC_LEN_C);
  assign release_out = (state == HOLD) && out_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a closing beat (in_last or full count) moves to HOLD once,
  // and only the output handshake leaves HOLD.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACC: begin
        if (accept) begin
          state_nxt = closing ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Accumulator, beat counter and sticky saturation flag; cleared as the result is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt_inc;
      sat <= sat | ovf;
    end else if (release_out) begin
      acc <= '0;
      cnt <= '0;
      sat <= 1'b0;
    end
  end

endmodule
